// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM state encoding and SC result codes.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    SC_FAIL = 2'd3
  } arb_state_e;

  // Store-conditional result word LSB: 0 = success, 1 = failure
  localparam logic SC_RES_OK   = 1'b0;
  localparam logic SC_RES_FAIL = 1'b1;

endpackage

// File: rtl/lr_sc_reservation.sv
// Single LR/SC reservation for the data requester: holds one valid bit and one word address.
module lr_sc_reservation #(
  parameter int WORD_W = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set,
  input  logic              clr,
  input  logic [WORD_W-1:0] set_word,
  input  logic [WORD_W-1:0] chk_word,
  output logic              match
);

  logic              valid_r;
  logic [WORD_W-1:0] word_r;

  // Clear wins over set; the arbiter never raises both in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= 1'b0;
      word_r  <= '0;
    end else if (clr) begin
      valid_r <= 1'b0;
    end else if (set) begin
      valid_r <= 1'b1;
      word_r  <= set_word;
    end
  end

  assign match = valid_r && (word_r == chk_word);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between fetch (I) and load/store (D), D priority with an I starvation guard.
// Optional LR/SC reservation tracking is enabled by defining ATOMIC_RESERVATION_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_lr,
  input  logic              d_sc,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_e       state_r, state_s;
  logic [CNT_W-1:0] starve_cnt_r;
  logic             sc_r;
  logic             if_pend_s, d_pend_s, grant_d_s, grant_i_s, is_store_s, sc_fail_s;

  // A requester's req is still up during its own ready cycle; no grants then, which also gives the IDLE gap
  assign if_pend_s  = if_req && !if_ready && !d_ready;
  assign d_pend_s   = d_req && !if_ready && !d_ready;
  assign grant_d_s  = (state_r == IDLE) && d_pend_s && !(if_pend_s && (starve_cnt_r == CNT_MAX));
  assign grant_i_s  = (state_r == IDLE) && if_pend_s && !grant_d_s;
  assign is_store_s = (d_we && !d_lr) || d_sc;

`ifdef ATOMIC_RESERVATION_EN
  logic lr_r, resv_match_s, resv_set_s, resv_clr_s;

  assign resv_clr_s = grant_d_s && (d_sc || (is_store_s && resv_match_s));
  assign resv_set_s = (state_r == SERVE_D) && mem_ack && lr_r;
  assign sc_fail_s  = d_sc && !resv_match_s;

  lr_sc_reservation #(.WORD_W(ADDR_W - 2)) u_resv (
    .clk      (clk),
    .reset    (reset),
    .set      (resv_set_s),
    .clr      (resv_clr_s),
    .set_word (mem_addr[ADDR_W-1:2]),
    .chk_word (d_addr[ADDR_W-1:2]),
    .match    (resv_match_s)
  );

  // Remember whether the granted D access is a load-reserved (LR together with SC counts as SC)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lr_r <= 1'b0;
    end else if (grant_d_s) begin
      lr_r <= d_lr && !d_sc;
    end
  end
`else
  assign sc_fail_s = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_d_s) begin
          state_s = sc_fail_s ? SC_FAIL : SERVE_D;
        end else if (grant_i_s) begin
          state_s = SERVE_I;
        end else begin
          state_s = IDLE;
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_ack) begin
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      SC_FAIL: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Memory command latch, response capture, ready pulses and the starvation counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      if_ready     <= 1'b0;
      if_rdata     <= '0;
      d_ready      <= 1'b0;
      d_rdata      <= '0;
      starve_cnt_r <= '0;
      sc_r         <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_d_s) begin
            sc_r <= d_sc;
            if (!sc_fail_s) begin
              mem_req   <= 1'b1;
              mem_we    <= is_store_s;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end
            if (if_pend_s && (starve_cnt_r != CNT_MAX)) begin
              starve_cnt_r <= starve_cnt_r + CNT_W'(1);
            end
          end else if (grant_i_s) begin
            mem_req      <= 1'b1;
            mem_we       <= 1'b0;
            mem_addr     <= if_addr;
            starve_cnt_r <= '0;
          end
        end
        SERVE_I: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            if_rdata <= mem_rdata;
            if_ready <= 1'b1;
          end
        end
        SERVE_D: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            d_rdata <= sc_r ? {{(DATA_W-1){1'b0}}, SC_RES_OK} : mem_rdata;
            d_ready <= 1'b1;
          end
        end
        SC_FAIL: begin
          d_rdata <= {{(DATA_W-1){1'b0}}, SC_RES_FAIL};
          d_ready <= 1'b1;
        end
        default: begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule
